operand_stack: RTL

- LIFO operand stack for the stack-machine CPU.
- Sits directly downstream of the CPU control unit. It takes push, pop and data_to_push from the control unit, and returns the top of stack on data_from_stack.
- Also exposes next-on-stack (nos), so two-operand ALU instructions can see both operands.
- Provides depth, full and empty status, plus sticky overflow and underflow error flags, for debug and trap logic.

---
 rtl/operand_stack_if.sv | 28 ++
 rtl/operand_stack.sv | 82 ++++++++
 2 files changed

// File: rtl/operand_stack_if.sv
// Control-unit <-> operand stack bundle: request side driven by the CPU
// control unit (master), status/read side driven by the stack (slave).
interface operand_stack_if #(
  parameter int WIDTH = 8,
  parameter int PTR_W = 4
);
  logic             push;
  logic             pop;
  logic             clear;
  logic [WIDTH-1:0] data_to_push;
  logic [WIDTH-1:0] data_from_stack;
  logic [WIDTH-1:0] nos;
  logic [PTR_W:0]   depth;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, clear, data_to_push,
    input  data_from_stack, nos, depth, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, clear, data_to_push,
    output data_from_stack, nos, depth, empty, full, overflow, underflow
  );
endinterface

// File: rtl/operand_stack.sv
// LIFO operand stack for the stack-machine CPU: exposes TOS and NOS
// combinationally, saturating pointer, sticky overflow/underflow flags.
module operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input logic           clk,
  input logic           reset,
  operand_stack_if.slave bus
);

  localparam logic [PTR_W:0] SP_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] SP_ONE  = (PTR_W+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   sp;
  logic             overflow_q;
  logic             underflow_q;

  logic             is_empty;
  logic             is_full;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] nos_idx;
  logic [PTR_W-1:0] wr_idx;
  logic             wr_en;

  assign is_empty = (sp == '0);
  assign is_full  = (sp == SP_FULL);

  // Modular index arithmetic is safe: the results are only used when sp
  // guarantees the entry is valid.
  assign top_idx = sp[PTR_W-1:0] - PTR_W'(1);
  assign nos_idx = sp[PTR_W-1:0] - PTR_W'(2);

  // Push+pop on a non-empty stack rewrites the top; otherwise push lands at sp.
  assign wr_idx = (bus.pop && !is_empty) ? top_idx : sp[PTR_W-1:0];
  assign wr_en  = bus.push && !bus.clear && (bus.pop || !is_full);

  assign bus.data_from_stack = is_empty ? '0 : mem[top_idx];
  assign bus.nos             = (sp > SP_ONE) ? mem[nos_idx] : '0;
  assign bus.depth           = sp;
  assign bus.empty           = is_empty;
  assign bus.full            = is_full;
  assign bus.overflow        = overflow_q;
  assign bus.underflow       = underflow_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= bus.data_to_push;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp          <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clear) begin
      sp          <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.push && bus.pop) begin
      if (is_empty) begin
        sp <= SP_ONE;
      end
    end else if (bus.push) begin
      if (is_full) begin
        overflow_q <= 1'b1;
      end else begin
        sp <= sp + SP_ONE;
      end
    end else if (bus.pop) begin
      if (is_empty) begin
        underflow_q <= 1'b1;
      end else begin
        sp <= sp - SP_ONE;
      end
    end
  end

endmodule
